fetch_controller: RTL

Sequences instruction fetch from the 128-word, word-indexed instruction memory. It owns the program counter and drives the memory address. It registers the returned word into an instruction register (IR) and presents it to decode over a valid/ready handshake. It also handles branch/jump redirects, halts, and out-of-range address errors.

---
 rtl/fetch_controller_if.sv | 43 ++++
 rtl/fetch_controller.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// Purpose: bundle of instruction-memory, decode-handshake and control signals for fetch_controller.
// Latency: n/a (wiring only).
// Backpressure: decode applies backpressure through ready against valid.
//
// Optional feature macro: FETCH_PERF_COUNTERS_EN adds fetch_count/stall_count.
// master: the fetch controller (drives address, instruction, instr_pc, valid, addr_err, state).
// slave : memory/decode/branch side (drives instr_in, ready, redirect, target, halt, resume).
interface fetch_controller_if;
  logic [31:0] address;      // fetch address (= PC register)
  logic [31:0] instr_in;     // memory word at address, combinational
  logic [31:0] instruction;  // IR presented to decode
  logic [31:0] instr_pc;     // PC of the word held in IR
  logic        valid;        // IR holds an undelivered instruction
  logic        ready;        // decode accepts IR this cycle
  logic        redirect;     // branch/jump taken
  logic [31:0] target;       // redirect address, low two bits ignored
  logic        halt;         // request fetch stop
  logic        resume;       // leave HALT when no address error
  logic        addr_err;     // sticky out-of-range flag
  logic [1:0]  state;        // IDLE=0, FETCH=1, HALT=2
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;  // IR loads, saturating
  logic [31:0] stall_count;  // FETCH cycles with valid && !ready, saturating

  modport master (
    output address, instruction, instr_pc, valid, addr_err, state, fetch_count, stall_count,
    input  instr_in, ready, redirect, target, halt, resume
  );
  modport slave (
    input  address, instruction, instr_pc, valid, addr_err, state, fetch_count, stall_count,
    output instr_in, ready, redirect, target, halt, resume
  );
`else
  modport master (
    output address, instruction, instr_pc, valid, addr_err, state,
    input  instr_in, ready, redirect, target, halt, resume
  );
  modport slave (
    input  address, instruction, instr_pc, valid, addr_err, state,
    output instr_in, ready, redirect, target, halt, resume
  );
`endif
endinterface

// File: rtl/fetch_controller.sv
// Purpose: owns the PC, fetches from word-indexed instruction memory into an IR, handles redirect/halt/range errors.
// Latency: first valid two edges after reset release; redirect-to-valid two edges; 1 instr/cycle streaming.
// Backpressure: valid/ready; with valid && !ready the IR, instr_pc and valid hold and the PC does not advance.
//
// Ports: clk (rising edge), reset (async, active-low), bus (fetch_controller_if.master).
// Optional feature macro: FETCH_PERF_COUNTERS_EN adds saturating fetch_count/stall_count.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128
) (
  input  logic             clk,
  input  logic             reset,
  fetch_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] PC_INIT = RESET_PC & ~32'd3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        load;
  logic        xfer;
  logic        in_range;

  assign xfer     = valid_q & bus.ready;
  // Word index compare covers wrap-around too: a wrapped PC lands at 0, but any
  // PC beyond the memory is caught before it is ever used for a load.
  assign in_range = ({2'b00, pc_q[31:2]} < 32'(MEM_WORDS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      ir_q    <= 32'd0;
      ir_pc_q <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    err_d   = err_q;
    load    = 1'b0;

    if (bus.redirect) begin
      // Redirect flushes the IR (a same-cycle transfer is cancelled) and
      // overrides halt/resume. The range check then applies to the new PC.
      pc_d    = bus.target & ~32'd3;
      valid_d = 1'b0;
      if (state_q != FETCH && state_q != HALT) begin
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (!in_range) begin
            // No load; whatever is already in the IR stays deliverable.
            err_d   = 1'b1;
            state_d = HALT;
            if (xfer) valid_d = 1'b0;
          end else if (bus.halt) begin
            state_d = HALT;
            if (xfer) valid_d = 1'b0;
          end else if (!valid_q || bus.ready) begin
            load    = 1'b1;
            ir_d    = bus.instr_in;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
        HALT: begin
          if (xfer) valid_d = 1'b0;
          // Halt held together with resume keeps us parked.
          if (bus.resume && !bus.halt && !err_q) begin
            state_d = FETCH;
          end
        end
        default: begin
          // IDLE (and the unused encoding) step into FETCH on the first edge.
          state_d = FETCH;
        end
      endcase
    end
  end

  assign bus.address     = pc_q;
  assign bus.instruction = ir_q;
  assign bus.instr_pc    = ir_pc_q;
  assign bus.valid       = valid_q;
  assign bus.addr_err    = err_q;
  assign bus.state       = state_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Counters survive redirects and only clear on reset; both saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (load && fetch_cnt_q != 32'hFFFF_FFFF) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (state_q == FETCH && valid_q && !bus.ready && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`endif

endmodule
